// File: rtl/wb_bridge_pkg.sv
// ---------------------------------------------------------------------------
// wb_bridge_pkg
// Shared definitions for the Wishbone-to-target bridge:
//   state_t           bridge FSM states (IDLE, REQ, ACK)
//   DEFAULT_ERR_DATA  read data returned on address miss or target timeout
//   idx_width()       width of the target index field, never below 1 bit
// ---------------------------------------------------------------------------
package wb_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;

    // A single target still gets one index bit so the address map keeps a
    // well-formed index field.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wb_bridge_decode.sv
// ---------------------------------------------------------------------------
// wb_bridge_decode
// Combinational address decode for the bridge.
//   adr_hi  in   address bits [31:WIN_BITS] (the in-window offset is not needed)
//   hit     out  address lies in the bridge region and selects an existing target
//   idx     out  target index, address bits [WIN_BITS+IDX_W-1:WIN_BITS]
// ---------------------------------------------------------------------------
module wb_bridge_decode
    import wb_bridge_pkg::*;
#(
    parameter int          NUM_TARGETS = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int          WIN_BITS    = 16,
    parameter int          IDX_W       = idx_width(NUM_TARGETS)
) (
    input  logic [31-WIN_BITS:0] adr_hi,
    output logic                 hit,
    output logic [IDX_W-1:0]     idx
);

    localparam int              HI_W    = 32 - WIN_BITS;
    localparam logic [HI_W-1:0] BASE_HI = HI_W'(BASE_ADDR >> WIN_BITS);

    logic tag_match;
    logic in_range;

    always_comb begin
        // Bits above the index field must equal the bridge base.
        tag_match = ((adr_hi >> IDX_W) == (BASE_HI >> IDX_W));
        idx       = adr_hi[IDX_W-1:0];
        // Non-power-of-two target counts leave unused index codes; those miss.
        in_range  = (32'(idx) < 32'(NUM_TARGETS));
        hit       = tag_match & in_range;
    end

endmodule

// File: rtl/wb_target_bridge.sv
// ---------------------------------------------------------------------------
// wb_target_bridge
// Wishbone classic slave that forwards each transfer to one of NUM_TARGETS
// simple request/ack targets, each owning a 2^WIN_BITS byte window above
// BASE_ADDR. Misses and target timeouts complete with ERR_DATA and bump a
// saturating error counter.
//   wb_clk_i, wb_rst_i         clock, asynchronous active-high reset
//   wbs_cyc/stb/we/sel/adr/dat Wishbone slave inputs
//   wbs_ack_o, wbs_dat_o       one-cycle ack and read data
//   t_req_o                    one-hot target request
//   t_we/sel/addr/wdata_o      transfer fields latched at request time
//   t_ack_i, t_rdata_i         per-target ack and read data (32 bits each)
//   timeout_o                  one-cycle pulse when a target fails to ack
//   err_count_o                saturating miss + timeout count
// ---------------------------------------------------------------------------
module wb_target_bridge
    import wb_bridge_pkg::*;
#(
    parameter int          NUM_TARGETS = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int          WIN_BITS    = 16,
    parameter int          TIMEOUT     = 255,
    parameter logic [31:0] ERR_DATA    = DEFAULT_ERR_DATA
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic                      wbs_cyc_i,
    input  logic                      wbs_stb_i,
    input  logic                      wbs_we_i,
    input  logic [3:0]                wbs_sel_i,
    input  logic [31:0]               wbs_adr_i,
    input  logic [31:0]               wbs_dat_i,
    output logic                      wbs_ack_o,
    output logic [31:0]               wbs_dat_o,
    output logic [NUM_TARGETS-1:0]    t_req_o,
    output logic                      t_we_o,
    output logic [3:0]                t_sel_o,
    output logic [WIN_BITS-1:0]       t_addr_o,
    output logic [31:0]               t_wdata_o,
    input  logic [NUM_TARGETS-1:0]    t_ack_i,
    input  logic [32*NUM_TARGETS-1:0] t_rdata_i,
    output logic                      timeout_o,
    output logic [7:0]                err_count_o
);

    localparam int          IDX_W    = idx_width(NUM_TARGETS);
    localparam int          NSLOT    = 1 << IDX_W;
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    // Address decode
    logic             dec_hit;
    logic [IDX_W-1:0] dec_idx;

    wb_bridge_decode #(
        .NUM_TARGETS (NUM_TARGETS),
        .BASE_ADDR   (BASE_ADDR),
        .WIN_BITS    (WIN_BITS),
        .IDX_W       (IDX_W)
    ) u_decode (
        .adr_hi (wbs_adr_i[31:WIN_BITS]),
        .hit    (dec_hit),
        .idx    (dec_idx)
    );

    // Target ack/data padded out to every index code so a latched index can
    // select them without an out-of-range access.
    logic [NSLOT-1:0]       ack_slot;
    logic [31:0]            rdata_slot [NSLOT];
    logic [NUM_TARGETS-1:0] req_onehot;

    for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
        if (gi < NUM_TARGETS) begin : g_real
            assign ack_slot[gi]   = t_ack_i[gi];
            assign rdata_slot[gi] = t_rdata_i[32*gi +: 32];
        end else begin : g_pad
            assign ack_slot[gi]   = 1'b0;
            assign rdata_slot[gi] = '0;
        end
    end

    for (genvar gi = 0; gi < NUM_TARGETS; gi++) begin : g_req
        assign req_onehot[gi] = (dec_idx == IDX_W'(gi));
    end

    // Registered state
    state_t                 state_reg,  state_next;
    logic [15:0]            cnt_reg,    cnt_next;
    logic [IDX_W-1:0]       idx_reg,    idx_next;
    logic [NUM_TARGETS-1:0] req_reg,    req_next;
    logic                   we_reg,     we_next;
    logic [3:0]             sel_reg,    sel_next;
    logic [WIN_BITS-1:0]    addr_reg,   addr_next;
    logic [31:0]            wdata_reg,  wdata_next;
    logic                   ack_reg,    ack_next;
    logic [31:0]            dat_reg,    dat_next;
    logic                   tmo_reg,    tmo_next;
    logic [7:0]             err_reg,    err_next;

    logic [7:0] err_inc;
    assign err_inc = (err_reg == 8'hFF) ? err_reg : err_reg + 8'd1;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            req_reg   <= '0;
            we_reg    <= 1'b0;
            sel_reg   <= '0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            ack_reg   <= 1'b0;
            dat_reg   <= '0;
            tmo_reg   <= 1'b0;
            err_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            req_reg   <= req_next;
            we_reg    <= we_next;
            sel_reg   <= sel_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            ack_reg   <= ack_next;
            dat_reg   <= dat_next;
            tmo_reg   <= tmo_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        req_next   = req_reg;
        we_next    = we_reg;
        sel_next   = sel_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        ack_next   = 1'b0;
        dat_next   = dat_reg;
        tmo_next   = 1'b0;
        err_next   = err_reg;

        unique case (state_reg)
            IDLE: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    if (dec_hit) begin
                        state_next = REQ;
                        cnt_next   = '0;
                        idx_next   = dec_idx;
                        req_next   = req_onehot;
                        we_next    = wbs_we_i;
                        sel_next   = wbs_sel_i;
                        addr_next  = wbs_adr_i[WIN_BITS-1:0];
                        wdata_next = wbs_dat_i;
                    end else begin
                        state_next = ACK;
                        ack_next   = 1'b1;
                        dat_next   = ERR_DATA;
                        err_next   = err_inc;
                    end
                end
            end

            REQ: begin
                if (!wbs_cyc_i) begin
                    // Master abandoned the cycle: drop silently.
                    state_next = IDLE;
                    req_next   = '0;
                end else if (ack_slot[idx_reg]) begin
                    // Ack is checked before the timeout so a last-cycle ack wins.
                    state_next = ACK;
                    req_next   = '0;
                    ack_next   = 1'b1;
                    dat_next   = we_reg ? 32'h0 : rdata_slot[idx_reg];
                end else if (cnt_reg == TMO_LAST) begin
                    state_next = ACK;
                    req_next   = '0;
                    ack_next   = 1'b1;
                    dat_next   = ERR_DATA;
                    tmo_next   = 1'b1;
                    err_next   = err_inc;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end

            ACK: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
                req_next   = '0;
            end
        endcase
    end

    assign wbs_ack_o   = ack_reg;
    assign wbs_dat_o   = dat_reg;
    assign t_req_o     = req_reg;
    assign t_we_o      = we_reg;
    assign t_sel_o     = sel_reg;
    assign t_addr_o    = addr_reg;
    assign t_wdata_o   = wdata_reg;
    assign timeout_o   = tmo_reg;
    assign err_count_o = err_reg;

endmodule

// File: tb/tb_wb_target_bridge.sv
// ---------------------------------------------------------------------------
// tb_wb_target_bridge
// Self-checking bench for wb_target_bridge (2 targets, TIMEOUT=4). The bench
// plays both the Wishbone master and the targets; expected results come from
// a fixed vector table and from a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_wb_target_bridge;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;
    localparam int          TMO  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = 32'h0, wdat = 32'h0;
    logic        ack;
    logic [31:0] rdat;
    logic [1:0]  t_req;
    logic        t_we;
    logic [3:0]  t_sel;
    logic [15:0] t_addr;
    logic [31:0] t_wdata;
    logic [1:0]  t_ack = 2'b00;
    logic [63:0] t_rdata = 64'h0;
    logic        tmo;
    logic [7:0]  errc;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_err  = 0;
    int xfer_no  = 0;

    always #5 clk = ~clk;

    wb_target_bridge #(
        .NUM_TARGETS (2),
        .BASE_ADDR   (BASE),
        .WIN_BITS    (16),
        .TIMEOUT     (TMO),
        .ERR_DATA    (ERRD)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wbs_cyc_i   (cyc),
        .wbs_stb_i   (stb),
        .wbs_we_i    (we),
        .wbs_sel_i   (sel),
        .wbs_adr_i   (adr),
        .wbs_dat_i   (wdat),
        .wbs_ack_o   (ack),
        .wbs_dat_o   (rdat),
        .t_req_o     (t_req),
        .t_we_o      (t_we),
        .t_sel_o     (t_sel),
        .t_addr_o    (t_addr),
        .t_wdata_o   (t_wdata),
        .t_ack_i     (t_ack),
        .t_rdata_i   (t_rdata),
        .timeout_o   (tmo),
        .err_count_o (errc)
    );

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] wdata;
        int          delay;     // target acks this many cycles after t_req_o appears
        logic [31:0] rdata;
        int          exp_lat;   // cycles from request edge to wbs_ack_o
        logic [31:0] exp_dat;
        logic        exp_tmo;
        logic [1:0]  exp_req;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Transaction-level reference: a bridge hit reaches the target named by
    // address bit 16; the target's ack wins if it lands within TMO request
    // cycles, otherwise the bridge gives up after TMO cycles.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        logic hit;
        int   idx;
        r   = v;
        hit = ((v.adr >> 17) == (BASE >> 17));
        idx = int'(v.adr[16]);
        if (!hit) begin
            r.exp_lat = 1;
            r.exp_dat = ERRD;
            r.exp_tmo = 1'b0;
            r.exp_req = 2'b00;
        end else if (v.delay < TMO) begin
            r.exp_lat = v.delay + 2;
            r.exp_dat = v.we ? 32'h0 : v.rdata;
            r.exp_tmo = 1'b0;
            r.exp_req = 2'(1 << idx);
        end else begin
            r.exp_lat = TMO + 1;
            r.exp_dat = ERRD;
            r.exp_tmo = 1'b1;
            r.exp_req = 2'(1 << idx);
        end
        return r;
    endfunction

    // Runs one transfer starting just after a falling edge and checks it.
    task automatic apply(input vec_t v);
        int          lat;
        int          rc;
        int          tidx;
        logic [31:0] dat_seen;
        logic        tmo_seen;
        logic [1:0]  req_seen;
        logic [15:0] f_addr;
        logic        f_we;
        logic [3:0]  f_sel;
        logic [31:0] f_wd;
        logic        stable;
        lat = -1; rc = 0; dat_seen = 32'h0; tmo_seen = 1'b0; req_seen = 2'b00;
        f_addr = 16'h0; f_we = 1'b0; f_sel = 4'h0; f_wd = 32'h0; stable = 1'b1;
        tidx = int'(v.adr[16]);
        xfer_no++;

        cyc = 1'b1; stb = 1'b1; we = v.we; sel = v.sel; adr = v.adr; wdat = v.wdata;
        for (int n = 1; n <= 20 && lat < 0; n++) begin
            @(negedge clk);
            // Request already sampled; scrambling proves the fields were latched.
            adr = $urandom; wdat = $urandom; sel = 4'($urandom); we = 1'($urandom);
            tmo_seen = tmo_seen | tmo;
            if (ack) begin
                lat      = n;
                dat_seen = rdat;
            end
            if (t_req != 2'b00) begin
                rc++;
                if (rc == 1) begin
                    req_seen = t_req; f_addr = t_addr; f_we = t_we; f_sel = t_sel; f_wd = t_wdata;
                end else if ({t_req, t_addr, t_we, t_sel, t_wdata} != {req_seen, f_addr, f_we, f_sel, f_wd}) begin
                    stable = 1'b0;
                end
            end
            t_ack   = 2'b00;
            t_rdata = {~v.rdata, ~v.rdata};
            t_rdata[32*tidx +: 32] = v.rdata;
            if (t_req != 2'b00) begin
                if (rc == v.delay + 1) t_ack[tidx] = 1'b1;
                // Stray acks from the other target must be ignored.
                if ($urandom_range(0, 1) == 1) t_ack[1-tidx] = 1'b1;
            end
            if (lat > 0) begin
                cyc = 1'b0; stb = 1'b0; t_ack = 2'b00;
            end
        end
        @(negedge clk);
        check("ack_width", {30'h0, ack, tmo}, 32'h0);

        if ((v.exp_tmo || v.exp_req == 2'b00) && exp_err < 255) exp_err++;

        check("latency", 32'(lat), 32'(v.exp_lat));
        check("rdata", dat_seen, v.exp_dat);
        check("timeout", {31'h0, tmo_seen}, {31'h0, v.exp_tmo});
        check("t_req", {30'h0, req_seen}, {30'h0, v.exp_req});
        check("err_count", {24'h0, errc}, 32'(exp_err));
        if (v.exp_req != 2'b00) begin
            check("t_addr", {16'h0, f_addr}, {16'h0, v.adr[15:0]});
            check("t_we", {31'h0, f_we}, {31'h0, v.we});
            check("t_sel", {28'h0, f_sel}, {28'h0, v.sel});
            check("t_wdata", f_wd, v.wdata);
            check("t_stable", {31'h0, stable}, 32'h1);
        end
        $display("xfer %0d adr=%08h we=%0b delay=%0d lat=%0d dat=%08h tmo=%0b req=%02b err=%0d",
                 xfer_no, v.adr, v.we, v.delay, lat, dat_seen, tmo_seen, req_seen, errc);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        logic seen_ack;
        logic seen_tmo;

        //               adr            we    sel    wdata          dly rdata          lat exp_dat        tmo   req
        tbl[0] = '{32'h3001_0010, 1'b0, 4'hF, 32'h0000_0000, 2, 32'h1234_5678, 4, 32'h1234_5678, 1'b0, 2'b10};
        tbl[1] = '{32'h3000_0004, 1'b1, 4'h3, 32'hA5A5_A5A5, 0, 32'hFFFF_0000, 2, 32'h0000_0000, 1'b0, 2'b01};
        tbl[2] = '{32'h4000_0000, 1'b0, 4'hF, 32'h0000_0000, 0, 32'h1111_1111, 1, 32'hDEAD_BEEF, 1'b0, 2'b00};
        tbl[3] = '{32'h3000_0100, 1'b0, 4'hF, 32'h0000_0000, 9, 32'h2222_2222, 5, 32'hDEAD_BEEF, 1'b1, 2'b01};
        tbl[4] = '{32'h3001_0200, 1'b0, 4'hF, 32'h0000_0000, 3, 32'hCAFE_F00D, 5, 32'hCAFE_F00D, 1'b0, 2'b10};
        tbl[5] = '{32'h3002_0000, 1'b0, 4'hF, 32'h0000_0000, 0, 32'h3333_3333, 1, 32'hDEAD_BEEF, 1'b0, 2'b00};

        // Reset takes effect without a clock edge.
        #2 rst = 1'b1;
        #1;
        check("reset_outputs", {t_req, ack, tmo, errc, t_we, t_sel}, 32'h0);
        check("reset_dat", rdat, 32'h0);
        check("reset_fields", {t_addr, 16'h0} | t_wdata, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) apply(tbl[i]);

        for (int i = 0; i < 40; i++) begin
            int kind;
            kind    = $urandom_range(0, 2);
            v.adr   = (kind == 2) ? 32'($urandom) : (BASE | (32'(kind) << 16) | 32'($urandom_range(0, 65535)));
            v.we    = 1'($urandom);
            v.sel   = 4'($urandom);
            v.wdata = $urandom;
            v.delay = $urandom_range(0, 6);
            v.rdata = $urandom;
            v       = model(v);
            apply(v);
        end

        // Master drops cyc mid-request: no ack, no error, request withdrawn.
        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h3001_0040; t_ack = 2'b00;
        @(negedge clk);
        check("abort_req_set", {30'h0, t_req}, 32'h2);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        seen_ack = 1'b0; seen_tmo = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            seen_ack = seen_ack | ack;
            seen_tmo = seen_tmo | tmo;
            if (n == 0) check("abort_req_clear", {30'h0, t_req}, 32'h0);
        end
        check("abort_no_ack", {30'h0, seen_ack, seen_tmo}, 32'h0);
        check("abort_err", {24'h0, errc}, 32'(exp_err));
        $display("xfer abort adr=30010040 ack=%0b tmo=%0b err=%0d", seen_ack, seen_tmo, errc);

        // Reset during an outstanding request drops it at once.
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0080;
        @(negedge clk);
        check("rst_req_set", {30'h0, t_req}, 32'h1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_req", {22'h0, t_req, ack, tmo, errc}, 32'h0);
        check("rst_mid_dat", rdat, 32'h0);
        exp_err = 0;
        cyc = 1'b0; stb = 1'b0;
        seen_ack = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            seen_ack = seen_ack | ack;
        end
        rst = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            seen_ack = seen_ack | ack;
        end
        check("rst_no_ack", {31'h0, seen_ack}, 32'h0);
        $display("xfer reset-drop adr=30000080 ack=%0b err=%0d", seen_ack, errc);

        v = '{32'h3001_0008, 1'b0, 4'hF, 32'h0, 1, 32'h0BAD_CAFE, 3, 32'h0BAD_CAFE, 1'b0, 2'b10};
        apply(v);

        // Drive enough misses to pin the error counter at its ceiling.
        for (int i = 0; i < 260; i++) begin
            v.adr   = 32'h4000_0000 + 32'(i * 4);
            v.we    = 1'b0;
            v.sel   = 4'hF;
            v.wdata = 32'h0;
            v.delay = 0;
            v.rdata = 32'h0;
            v       = model(v);
            apply(v);
        end
        check("err_saturated", {24'h0, errc}, 32'd255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
